// File: rtl/router_pkg.sv
// ============================================================================
// router_pkg : shared widths, header helpers and FIFO entry type for the router
// Rev 1.0
// ============================================================================
`default_nettype none

package router_pkg;

   localparam int ROUTER_DATA_W = 8;
   localparam int HDR_BIT       = ROUTER_DATA_W;

   typedef struct packed {
      logic                     hdr;
      logic [ROUTER_DATA_W-1:0] data;
   } fifo_entry_t;

   // Length field sits above the two destination-address bits of a header byte.
   function automatic logic [31:0] len_of(input logic [31:0] hdr_byte, input int data_w);
      logic [31:0] mask;
      mask = (data_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << data_w) - 32'd1);
      return (hdr_byte & mask) >> 2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/router_pkt_fifo_if.sv
// ============================================================================
// router_pkt_fifo_if : write/read handshake and status bundle of the packet FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

interface router_pkt_fifo_if
   import router_pkg::*;
#(
   parameter int DATA_W = ROUTER_DATA_W,
   parameter int DEPTH  = 16
) ();

   localparam int AW = $clog2(DEPTH);

   logic              wr_en;
   logic              lfd_state;
   logic [DATA_W-1:0] data_in;
   logic              rd_en;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic              pkt_last;
   logic              empty;
   logic              full;
   logic              almost_full;
   logic [AW:0]       count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, lfd_state, data_in, rd_en,
      input  data_out, rd_valid, pkt_last, empty, full, almost_full, count,
             overflow, underflow
   );

   modport slave (
      input  wr_en, lfd_state, data_in, rd_en,
      output data_out, rd_valid, pkt_last, empty, full, almost_full, count,
             overflow, underflow
   );

endinterface

`default_nettype wire

// File: rtl/router_fifo_mem.sv
// ============================================================================
// router_fifo_mem : dual-port register array, synchronous write, async read
// Rev 1.0
// ============================================================================
`default_nettype none

module router_fifo_mem #(
   parameter  int WIDTH = 9,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  wire logic             clk,
   input  wire logic             we,
   input  wire logic [AW-1:0]    waddr,
   input  wire logic [WIDTH-1:0] wdata,
   input  wire logic [AW-1:0]    raddr,
   output      logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/router_pkt_fifo.sv
// ============================================================================
// router_pkt_fifo : packet-aware FIFO with occupancy flags and read-side framing
// Rev 1.0
// ============================================================================
`default_nettype none

module router_pkt_fifo
   import router_pkg::*;
#(
   parameter int DATA_W   = ROUTER_DATA_W,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 14
) (
   input wire logic          clk,
   input wire logic          reset,
   input wire logic          soft_reset,
   router_pkt_fifo_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = DATA_W - 1;

   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_AF   = (AW+1)'(AF_LEVEL);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [PW-1:0] PKT_ONE  = PW'(1);

   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [AW:0]       count_q, count_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              rd_valid_q, rd_valid_d;
   logic              pkt_last_q, pkt_last_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic [PW-1:0]     pkt_cnt_q, pkt_cnt_d;

   logic              empty, full, wr_ok, rd_ok;
   logic [DATA_W:0]   rd_entry;
   logic [PW-1:0]     hdr_len;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_FULL);
   assign wr_ok = bus.wr_en & ~full;
   assign rd_ok = bus.rd_en & ~empty;

   router_fifo_mem #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_ok & ~soft_reset),
      .waddr (wptr_q),
      .wdata ({bus.lfd_state, bus.data_in}),
      .raddr (rptr_q),
      .rdata (rd_entry)
   );

   assign hdr_len = PW'(len_of(32'(rd_entry[DATA_W-1:0]), DATA_W));

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      rd_valid_d  = 1'b0;
      pkt_last_d  = pkt_last_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      pkt_cnt_d   = pkt_cnt_q;

      if (soft_reset) begin
         wptr_d      = '0;
         rptr_d      = '0;
         count_d     = '0;
         data_out_d  = '0;
         pkt_last_d  = 1'b0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
         pkt_cnt_d   = '0;
      end else begin
         overflow_d  = overflow_q  | (bus.wr_en & full);
         underflow_d = underflow_q | (bus.rd_en & empty);
         rd_valid_d  = rd_ok;

         if (wr_ok) begin
            wptr_d = wptr_q + PTR_ONE;
         end

         if (rd_ok) begin
            rptr_d     = rptr_q + PTR_ONE;
            data_out_d = rd_entry[DATA_W-1:0];
            // Header reload includes one extra byte for the trailing parity.
            if (rd_entry[DATA_W]) begin
               pkt_cnt_d  = hdr_len + PKT_ONE;
               pkt_last_d = 1'b0;
            end else begin
               pkt_last_d = (pkt_cnt_q == PKT_ONE);
               if (pkt_cnt_q != '0) begin
                  pkt_cnt_d = pkt_cnt_q - PKT_ONE;
               end
            end
         end

         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         rd_valid_q  <= 1'b0;
         pkt_last_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         pkt_cnt_q   <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         rd_valid_q  <= rd_valid_d;
         pkt_last_q  <= pkt_last_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

   assign bus.data_out    = data_out_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.pkt_last    = pkt_last_q;
   assign bus.empty       = empty;
   assign bus.full        = full;
   assign bus.almost_full = (count_q >= CNT_AF);
   assign bus.count       = count_q;
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;

endmodule

`default_nettype wire
